// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer:
// command opcodes, FSM states and the queued command record.
package apb_seq_pkg;

    localparam int CMD_ADDR_W = 9;
    localparam int CMD_DATA_W = 91;

    typedef enum logic [1:0] {
        OP_WR   = 2'd0,
        OP_RD   = 2'd1,
        OP_PAIR = 2'd2,
        OP_RSV  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_SETUP2,
        S_ACCESS2,
        S_RESP
    } state_e;

    typedef struct packed {
        cmd_op_e                 op;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_DATA_W-1:0]   data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/apb_seq_master_fifo.sv
// Show-ahead synchronous FIFO; the extra pointer MSB
// separates the full condition from the empty one.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_seq_master.sv
// APB master that drains a command FIFO into register writes,
// reads and RAM-load pairs, with one response per command.
module apb_seq_master
    import apb_seq_pkg::*;
#(
    parameter int ADDR_W        = CMD_ADDR_W,
    parameter int DATA_W        = CMD_DATA_W,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT       = 255,
    parameter int PAIR_ADDR_REG = 10,
    parameter int PAIR_DATA_REG = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (CW > 8) ? CW : 8;

    state_e            state;
    state_e            state_nx;
    cmd_t              in_cmd;
    cmd_t              head;
    logic              full;
    logic              empty;
    logic              pop;
    cmd_op_e           op_q;
    logic [DATA_W-1:0] data_hold;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timed_out;
    logic              in_access;

    assign in_cmd = '{op: cmd_op_e'(cmd_op), addr: cmd_addr, data: cmd_data};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign in_access = (state == S_ACCESS) || (state == S_ACCESS2);
    assign timed_out = !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign cmd_ready = !full;
    assign psel      = (state inside {S_SETUP, S_ACCESS, S_SETUP2, S_ACCESS2});
    assign penable   = in_access;
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_data  = rsp_valid ? rdata_q : '0;
    assign busy      = !empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE, S_RESP: begin
                state_nx = S_IDLE;
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = (head.op == OP_RSV) ? S_RESP : S_SETUP;
                end
            end
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: begin
                if (pready)
                    state_nx = (op_q == OP_PAIR) ? S_SETUP2 : S_RESP;
                else if (timed_out)
                    state_nx = S_RESP;
            end
            S_SETUP2: state_nx = S_ACCESS2;
            S_ACCESS2: begin
                if (pready || timed_out) state_nx = S_RESP;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            op_q      <= OP_WR;
            data_hold <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (pop) begin
                op_q      <= head.op;
                data_hold <= DATA_W'(head.data);
                rdata_q   <= '0;
                err_q     <= (head.op == OP_RSV);
                unique case (head.op)
                    OP_WR: begin
                        paddr  <= ADDR_W'(head.addr);
                        pwrite <= 1'b1;
                        pwdata <= DATA_W'(head.data);
                    end
                    OP_RD: begin
                        paddr  <= ADDR_W'(head.addr);
                        pwrite <= 1'b0;
                        pwdata <= '0;
                    end
                    OP_PAIR: begin
                        paddr  <= ADDR_W'(PAIR_ADDR_REG);
                        pwrite <= 1'b1;
                        pwdata <= DATA_W'(head.addr);
                    end
                    OP_RSV: begin
                    end
                endcase
            end
            if (state == S_SETUP || state == S_SETUP2)
                wait_cnt <= '0;
            if (in_access) begin
                if (pready) begin
                    if (!pwrite) rdata_q <= prdata;
                    // second half of a pair reuses the held payload
                    if (state == S_ACCESS && op_q == OP_PAIR) begin
                        paddr  <= ADDR_W'(PAIR_DATA_REG);
                        pwdata <= data_hold;
                    end
                end else if (timed_out) begin
                    err_q <= 1'b1;
                end else if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_seq_master.sv
// Bench for apb_seq_master: cycle tables for the fixed scenarios,
// then a transaction-level scoreboard under random traffic.
module tb_apb_seq_master;

    localparam int AW    = 9;
    localparam int DW    = 91;
    localparam int TMO   = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    always #5 clk = ~clk;

    apb_seq_master #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT       (TMO),
        .PAIR_ADDR_REG (10),
        .PAIR_DATA_REG (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    typedef struct {
        logic          vld;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rdy_in;
        logic [DW-1:0] prd;
        logic          psel;
        logic          pen;
        logic [AW-1:0] paddr;
        logic          pw;
        logic [DW-1:0] pwd;
        logic          rv;
        logic          rerr;
        logic [DW-1:0] rdata;
        logic          busy;
        logic          crdy;
    } row_t;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_rec_t;

    row_t     rows[$];
    cmd_rec_t cmd_q[$];

    int total = 0;
    int bad   = 0;
    bit mon     = 1'b0;
    bit fullchk = 1'b0;
    int stage   = 0;
    int wcnt    = 0;
    bit aborted = 1'b0;
    logic [DW-1:0] cap = '0;
    int pushed = 0;
    int setups = 0;
    int nrsp   = 0;

    function automatic row_t mk(
        input logic vld, input logic [1:0] op, input logic [AW-1:0] addr,
        input logic [DW-1:0] data, input logic rdy_in, input logic [DW-1:0] prd,
        input logic ps, input logic pen, input logic [AW-1:0] pa, input logic pw,
        input logic [DW-1:0] pwd, input logic rv, input logic rerr,
        input logic [DW-1:0] rdata, input logic bsy, input logic crdy);
        row_t r;
        r.vld = vld; r.op = op; r.addr = addr; r.data = data;
        r.rdy_in = rdy_in; r.prd = prd;
        r.psel = ps; r.pen = pen; r.paddr = pa; r.pw = pw; r.pwd = pwd;
        r.rv = rv; r.rerr = rerr; r.rdata = rdata; r.busy = bsy; r.crdy = crdy;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd91();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic check_eq(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input int i);
        row_t r;
        bit ok;
        r = rows[i];
        ok = (psel === r.psel) && (penable === r.pen) &&
             (rsp_valid === r.rv) && (rsp_err === r.rerr) &&
             (rsp_data === r.rdata) && (busy === r.busy) &&
             (cmd_ready === r.crdy);
        if (r.psel) ok = ok && (paddr === r.paddr) && (pwrite === r.pw);
        if (r.psel && r.pw) ok = ok && (pwdata === r.pwd);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL row%0d: got psel=%b pen=%b paddr=%0d pw=%b pwd=%0h rv=%b err=%b rd=%0h busy=%b rdy=%b want psel=%b pen=%b paddr=%0d pw=%b pwd=%0h rv=%b err=%b rd=%0h busy=%b rdy=%b",
                     i, psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_err,
                     rsp_data, busy, cmd_ready, r.psel, r.pen, r.paddr, r.pw,
                     r.pwd, r.rv, r.rerr, r.rdata, r.busy, r.crdy);
        end
    endtask

    // expected bus transfer number st of command c
    function automatic bit exp_xfer(input cmd_rec_t c, input int st,
                                    output logic [AW-1:0] a, output logic w,
                                    output logic [DW-1:0] d);
        a = '0; w = 1'b0; d = '0;
        exp_xfer = 1'b1;
        case (c.op)
            2'd0: if (st == 0) begin a = c.addr; w = 1'b1; d = c.data; end
                  else exp_xfer = 1'b0;
            2'd1: if (st == 0) begin a = c.addr; w = 1'b0; end
                  else exp_xfer = 1'b0;
            2'd2: if (st == 0) begin a = 9'd10; w = 1'b1; d = DW'(c.addr); end
                  else if (st == 1) begin a = 9'd11; w = 1'b1; d = c.data; end
                  else exp_xfer = 1'b0;
            default: exp_xfer = 1'b0;
        endcase
    endfunction

    task automatic monitor();
        cmd_rec_t      h;
        cmd_rec_t      n;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        bit            ok;
        logic          e_err;
        logic [DW-1:0] e_data;
        int            e_st;
        if (psel) begin
            check_eq("psel_owner", DW'(cmd_q.size() != 0 && !aborted), 1);
            if (!penable) begin
                setups++;
                wcnt = 0;
            end else if (cmd_q.size() != 0 && !aborted) begin
                ok = exp_xfer(cmd_q[0], stage, ea, ew, ed);
                if (pready) begin
                    check_eq("xfer_expected", DW'(ok), 1);
                    check_eq("xfer_paddr", DW'(paddr), DW'(ea));
                    check_eq("xfer_pwrite", DW'(pwrite), DW'(ew));
                    if (ew) check_eq("xfer_pwdata", pwdata, ed);
                    else cap = prdata;
                    stage++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                    if (wcnt >= TMO) aborted = 1'b1;
                end
            end
        end
        if (rsp_valid) begin
            check_eq("rsp_owner", DW'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0) begin
                h      = cmd_q.pop_front();
                e_err  = (h.op == 2'd3) || aborted;
                e_data = (h.op == 2'd1 && !aborted) ? cap : '0;
                e_st   = (h.op == 2'd2) ? 2 : ((h.op == 2'd3) ? 0 : 1);
                check_eq("rsp_err", DW'(rsp_err), DW'(e_err));
                check_eq("rsp_data", rsp_data, e_data);
                if (!aborted) check_eq("rsp_xfers", DW'(stage), DW'(e_st));
                nrsp++;
            end
            stage = 0; wcnt = 0; aborted = 1'b0; cap = '0;
        end
        if (fullchk)
            check_eq("cmd_ready", DW'(cmd_ready), DW'((pushed - setups) < DEPTH));
        if (cmd_valid && cmd_ready) begin
            n.op = cmd_op; n.addr = cmd_addr; n.data = cmd_data;
            cmd_q.push_back(n);
            pushed++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon) monitor();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] PD = 91'd57344;

    initial begin
        int nr;
        bit found;
        bit full_seen;
        int rejects;
        int k;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
        cmd_data = '0; prdata = '0; pready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_psel", DW'(psel), 0);
        check_eq("rst_penable", DW'(penable), 0);
        check_eq("rst_pwrite", DW'(pwrite), 0);
        check_eq("rst_paddr", DW'(paddr), 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_rsp", DW'({rsp_valid, rsp_err}), 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", DW'(busy), 0);
        check_eq("rst_cmd_ready", DW'(cmd_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // write op0 addr 2 data 5, zero wait
        rows.push_back(mk(1,0,2,5, 1,0, 0,0,0,0,0, 0,0,0, 0,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,0,2,1,5, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,1,2,1,5, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 1,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 0,0,0, 0,1));
        // pair op2 addr 9 data {13'd7,13'd0}
        rows.push_back(mk(1,2,9,PD, 1,0, 0,0,0,0,0, 0,0,0, 0,1));
        rows.push_back(mk(0,0,0,0,  1,0, 0,0,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 1,0,10,1,9, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 1,1,10,1,9, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 1,0,11,1,PD, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 1,1,11,1,PD, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 0,0,0,0,0, 1,0,0, 1,1));
        rows.push_back(mk(0,0,0,0,  1,0, 0,0,0,0,0, 0,0,0, 0,1));
        // read op1 addr 0 with three wait states
        rows.push_back(mk(1,1,0,0, 0,0, 0,0,0,0,0, 0,0,0, 0,1));
        rows.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,0,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,91'h2A, 1,1,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 1,0,91'h2A, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 0,0,0, 0,1));
        // timeout on a write, queued pair still runs both halves
        rows.push_back(mk(1,0,3,1, 0,0, 0,0,0,0,0, 0,0,0, 0,1));
        rows.push_back(mk(1,2,5,6, 0,0, 0,0,0,0,0, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,0,3,1,1, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,3,1,1, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,3,1,1, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,3,1,1, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 0,0, 1,1,3,1,1, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,0,10,1,5, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,1,10,1,5, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,0,11,1,6, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 1,1,11,1,6, 0,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 1,0,0, 1,1));
        rows.push_back(mk(0,0,0,0, 1,0, 0,0,0,0,0, 0,0,0, 0,1));

        for (int i = 0; i < rows.size(); i++) begin
            cmd_valid = rows[i].vld;
            cmd_op    = rows[i].op;
            cmd_addr  = rows[i].addr;
            cmd_data  = rows[i].data;
            pready    = rows[i].rdy_in;
            prdata    = rows[i].prd;
            @(negedge clk);
            check_row(i);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;

        // fill the FIFO while the bus stalls, then drain in order
        mon = 1'b1; fullchk = 1'b1;
        pushed = 0; setups = 0; nrsp = 0;
        pready = 1'b0; full_seen = 1'b0; rejects = 0;
        for (k = 0; k < 100 && rejects < 3; k++) begin
            cmd_valid = 1'b1; cmd_op = 2'd0;
            cmd_addr = AW'(k); cmd_data = DW'(1000 + k);
            if (!cmd_ready) begin
                rejects++;
                full_seen = 1'b1;
            end
            tick();
        end
        check_eq("fifo_full_seen", DW'(full_seen), 1);
        cmd_valid = 1'b0; pready = 1'b1;
        for (k = 0; k < 300 && (cmd_q.size() != 0 || busy); k++) tick();
        check_eq("full_drained", DW'(cmd_q.size() == 0 && !busy), 1);
        check_eq("full_rsp_count", DW'(nrsp), DW'(pushed));
        fullchk = 1'b0;

        // random traffic against the scoreboard
        for (k = 0; k < 1500; k++) begin
            int sel;
            cmd_valid = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            cmd_op = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            cmd_addr = AW'($urandom);
            cmd_data = rnd91();
            pready = ($urandom_range(0, 9) < 6);
            prdata = rnd91();
            tick();
        end
        cmd_valid = 1'b0; pready = 1'b1;
        for (k = 0; k < 600 && (cmd_q.size() != 0 || busy); k++) tick();
        check_eq("rand_drained", DW'(cmd_q.size() == 0 && !busy), 1);
        mon = 1'b0;

        // reset during ACCESS of the second of three writes
        nr = 0; found = 1'b0; pready = 1'b1;
        for (k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_op = 2'd0;
            cmd_addr = AW'(20 + k); cmd_data = DW'(k);
            @(negedge clk);
            if (rsp_valid) nr++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) nr++;
            if (psel && penable && paddr == AW'(21)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("rst_found_access2", DW'(found), 1);
        rst = 1'b1; pready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_psel", DW'({psel, penable}), 0);
        check_eq("rst_mid_busy", DW'(busy), 0);
        check_eq("rst_mid_ready", DW'(cmd_ready), 1);
        check_eq("rst_mid_rsp_before", DW'(nr), 1);
        nr = 0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || psel) nr++;
        end
        check_eq("rst_mid_quiet", DW'(nr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
